// File: rtl/spi_slave_burst_pkg.sv
// Shared SPI definitions: bit-order constants and default widths,
// common to the burst slave and its master counterpart.
package spi_slave_burst_pkg;

    localparam int SPI_LSB_FIRST = 0;
    localparam int SPI_MSB_FIRST = 1;

    localparam int SPI_DEFAULT_DATA_WIDTH  = 8;
    localparam int SPI_DEFAULT_COUNT_WIDTH = 8;

    typedef enum logic {
        BIT_ORDER_LSB = 1'b0,
        BIT_ORDER_MSB = 1'b1
    } bit_order_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parametrised serial shift register with parallel load and synchronous clear.
// The same direction rule serves both the TX and the RX path.
module spi_shift_reg
    import spi_slave_burst_pkg::*;
#(
    parameter int WIDTH     = SPI_DEFAULT_DATA_WIDTH,
    parameter int MSB_FIRST = SPI_LSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] shifted
);

    localparam bit_order_e ORDER = (MSB_FIRST == SPI_MSB_FIRST) ? BIT_ORDER_MSB : BIT_ORDER_LSB;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // The bit leaving the register is the one at the "first" end; new bits enter at the other end.
    always_comb begin
        shifted    = '0;
        serial_out = 1'b0;
        if (ORDER == BIT_ORDER_MSB) begin
            shifted    = {data_q[WIDTH-2:0], serial_in};
            serial_out = data_q[WIDTH-1];
        end else begin
            shifted    = {serial_in, data_q[WIDTH-1:1]};
            serial_out = data_q[0];
        end
    end

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave with configurable width and bit order, multi-word bursts under one CS,
// per-word strobe, word counter and mid-word abort detection. TX on posedge, RX on negedge.
module spi_slave_burst
    import spi_slave_burst_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DEFAULT_DATA_WIDTH,
    parameter int MSB_FIRST   = SPI_LSB_FIRST,
    parameter int COUNT_WIDTH = SPI_DEFAULT_COUNT_WIDTH
) (
    input  logic                   SCLK,
    input  logic                   reset,
    input  logic                   CS,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    output logic [DATA_WIDTH-1:0]  rx_data,
    output logic                   word_done,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   frame_err
);

    localparam int               BIT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic sclk_n;
    assign sclk_n = ~SCLK;

    // Posedge (TX) domain state
    logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
    logic             in_frame_q, in_frame_d;
    logic             start_tgl_q, start_tgl_d;
    logic             tx_clear, tx_load, tx_shift;
    logic             tx_serial;
    logic [DATA_WIDTH-1:0] tx_shifted_unused;

    // Negedge (RX) domain state
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   word_done_q, word_done_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d, count_base;
    logic                   err_q, err_d, err_base;
    logic                   ack_tgl_q, ack_tgl_d;
    logic                   rx_clear, rx_shift;
    logic [DATA_WIDTH-1:0]  rx_shifted;
    logic                   rx_serial_unused;

    logic frame_pending;

    spi_shift_reg #(
        .WIDTH     (DATA_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_shift (
        .clk        (SCLK),
        .reset      (reset),
        .clear      (tx_clear),
        .load       (tx_load),
        .load_data  (tx_data),
        .shift_en   (tx_shift),
        .serial_in  (1'b0),
        .serial_out (tx_serial),
        .shifted    (tx_shifted_unused)
    );

    spi_shift_reg #(
        .WIDTH     (DATA_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx_shift (
        .clk        (sclk_n),
        .reset      (reset),
        .clear      (rx_clear),
        .load       (1'b0),
        .load_data  ('0),
        .shift_en   (rx_shift),
        .serial_in  (MOSI),
        .serial_out (rx_serial_unused),
        .shifted    (rx_shifted)
    );

    // Frame start toggles start_tgl on the posedge; the negedge side acknowledges it
    // and until then the visible count/error already read as cleared.
    always_comb begin
        tx_bit_d    = tx_bit_q;
        in_frame_d  = in_frame_q;
        start_tgl_d = start_tgl_q;
        tx_clear    = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        if (CS) begin
            tx_bit_d   = '0;
            in_frame_d = 1'b0;
            tx_clear   = 1'b1;
        end else begin
            in_frame_d = 1'b1;
            if (!in_frame_q) begin
                start_tgl_d = ~start_tgl_q;
            end
            if (tx_bit_q == '0) begin
                tx_load = 1'b1;
            end else begin
                tx_shift = 1'b1;
            end
            tx_bit_d = (tx_bit_q == LAST_BIT) ? '0 : tx_bit_q + BIT_W'(1);
        end
    end

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            tx_bit_q    <= '0;
            in_frame_q  <= 1'b0;
            start_tgl_q <= 1'b0;
        end else begin
            tx_bit_q    <= tx_bit_d;
            in_frame_q  <= in_frame_d;
            start_tgl_q <= start_tgl_d;
        end
    end

    assign frame_pending = start_tgl_q ^ ack_tgl_q;

    always_comb begin
        count_base  = frame_pending ? '0 : count_q;
        err_base    = frame_pending ? 1'b0 : err_q;
        rx_bit_d    = rx_bit_q;
        rx_data_d   = rx_data_q;
        word_done_d = 1'b0;
        count_d     = count_base;
        err_d       = err_base;
        ack_tgl_d   = start_tgl_q;
        rx_clear    = 1'b0;
        rx_shift    = 1'b0;
        if (CS) begin
            rx_bit_d = '0;
            rx_clear = 1'b1;
            if (rx_bit_q != '0) begin
                err_d = 1'b1;
            end
        end else begin
            rx_shift = 1'b1;
            if (rx_bit_q == LAST_BIT) begin
                rx_bit_d    = '0;
                rx_data_d   = rx_shifted;
                word_done_d = 1'b1;
                count_d     = count_base + COUNT_WIDTH'(1);
            end else begin
                rx_bit_d = rx_bit_q + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge sclk_n or posedge reset) begin
        if (reset) begin
            rx_bit_q    <= '0;
            rx_data_q   <= '0;
            word_done_q <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            ack_tgl_q   <= 1'b0;
        end else begin
            rx_bit_q    <= rx_bit_d;
            rx_data_q   <= rx_data_d;
            word_done_q <= word_done_d;
            count_q     <= count_d;
            err_q       <= err_d;
            ack_tgl_q   <= ack_tgl_d;
        end
    end

    always_comb begin
        MISO       = tx_serial;
        rx_data    = rx_data_q;
        word_done  = word_done_q;
        word_count = frame_pending ? '0 : count_q;
        frame_err  = frame_pending ? 1'b0 : err_q;
    end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Testbench for spi_slave_burst: three parameter sets share the SPI lines,
// a queue-based reference model feeds a negedge monitor that checks every word.
module tb_spi_slave_burst;

   logic        SCLK = 1'b0;
   logic        reset = 1'b1;
   logic        csLine = 1'b1;
   logic        mosi = 1'b0;
   logic [15:0] txData = '0;
   int          sel = 0;

   logic        cs0, cs1, cs2;
   logic        miso0, miso1, miso2;
   logic [7:0]  rx0, rx1;
   logic [15:0] rx2;
   logic        wd0, wd1, wd2;
   logic [7:0]  wc0, wc1;
   logic [1:0]  wc2;
   logic        fe0, fe1, fe2;

   logic        misoMux;
   logic [15:0] rxMux;
   logic        wdMux;
   logic [7:0]  wcMux;
   logic        feMux;

   int cfgW   [3] = '{8, 8, 16};
   int cfgMsb [3] = '{0, 1, 1};
   int cfgCw  [3] = '{8, 8, 2};

   int checks = 0;
   int passes = 0;

   logic [15:0] expRxQ [$];
   int          expCntQ[$];
   logic [15:0] misoQ  [$];

   logic [15:0] mLastRx [3];
   int          mCount  [3];
   logic        mErr    [3];
   bit          firstWord = 1'b0;

   initial forever #5 SCLK = ~SCLK;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Only the selected instance ever sees CS low
   assign cs0 = (sel == 0) ? csLine : 1'b1;
   assign cs1 = (sel == 1) ? csLine : 1'b1;
   assign cs2 = (sel == 2) ? csLine : 1'b1;

   spi_slave_burst #(.DATA_WIDTH(8), .MSB_FIRST(0), .COUNT_WIDTH(8)) dut0 (
      .SCLK(SCLK), .reset(reset), .CS(cs0), .MOSI(mosi), .MISO(miso0),
      .tx_data(txData[7:0]), .rx_data(rx0), .word_done(wd0),
      .word_count(wc0), .frame_err(fe0));

   spi_slave_burst #(.DATA_WIDTH(8), .MSB_FIRST(1), .COUNT_WIDTH(8)) dut1 (
      .SCLK(SCLK), .reset(reset), .CS(cs1), .MOSI(mosi), .MISO(miso1),
      .tx_data(txData[7:0]), .rx_data(rx1), .word_done(wd1),
      .word_count(wc1), .frame_err(fe1));

   spi_slave_burst #(.DATA_WIDTH(16), .MSB_FIRST(1), .COUNT_WIDTH(2)) dut2 (
      .SCLK(SCLK), .reset(reset), .CS(cs2), .MOSI(mosi), .MISO(miso2),
      .tx_data(txData), .rx_data(rx2), .word_done(wd2),
      .word_count(wc2), .frame_err(fe2));

   // Route the selected instance's outputs onto common observation signals
   always_comb begin
      misoMux = miso0;
      rxMux   = {8'h00, rx0};
      wdMux   = wd0;
      wcMux   = wc0;
      feMux   = fe0;
      case (sel)
         1: begin
            misoMux = miso1; rxMux = {8'h00, rx1}; wdMux = wd1; wcMux = wc1; feMux = fe1;
         end
         2: begin
            misoMux = miso2; rxMux = rx2; wdMux = wd2; wcMux = {6'b0, wc2}; feMux = fe2;
         end
         default: ;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic logic [15:0] wordMask(input int w);
      return 16'((32'd1 << w) - 1);
   endfunction

   // Called just after a negedge with CS high; clears the per-frame model state
   task automatic startFrame();
      csLine = 1'b0;
      firstWord = 1'b1;
      mCount[sel] = 0;
      mErr[sel] = 1'b0;
   endtask

   // Send one full word m while offering t as the slave's reply
   task automatic applyStimulus(input logic [15:0] m, input logic [15:0] t);
      int w;
      int idx;
      logic [15:0] mask;
      w = cfgW[sel];
      mask = wordMask(w);
      txData = t;
      mCount[sel] = (mCount[sel] + 1) % (1 << cfgCw[sel]);
      mLastRx[sel] = m & mask;
      expRxQ.push_back(m & mask);
      expCntQ.push_back(mCount[sel]);
      misoQ.push_back(t & mask);
      for (int i = 0; i < w; i++) begin
         @(posedge SCLK); #1;
         if (i == 0 && firstWord) begin
            checkOutput("start_clears_err", 32'(feMux), 32'(mErr[sel]));
            checkOutput("start_clears_count", 32'(wcMux), 32'd0);
            firstWord = 1'b0;
         end
         idx = (cfgMsb[sel] != 0) ? (w - 1 - i) : i;
         mosi = m[idx];
         if (i == 3) txData = 16'($urandom);
         @(negedge SCLK); #1;
      end
   endtask

   task automatic sendPartial(input logic [15:0] m, input int nBits);
      int w;
      int idx;
      w = cfgW[sel];
      for (int i = 0; i < nBits; i++) begin
         @(posedge SCLK); #1;
         idx = (cfgMsb[sel] != 0) ? (w - 1 - i) : i;
         mosi = m[idx];
         @(negedge SCLK); #1;
      end
   endtask

   task automatic endFrame(input int abortBits);
      csLine = 1'b1;
      if (abortBits > 0) mErr[sel] = 1'b1;
      @(posedge SCLK); @(negedge SCLK); #1;
      checkOutput("end_rx_data", 32'(rxMux), 32'(mLastRx[sel]));
      checkOutput("end_word_count", 32'(wcMux), 32'(mCount[sel]));
      checkOutput("end_frame_err", 32'(feMux), 32'(mErr[sel]));
      checkOutput("end_miso_idle", 32'(misoMux), 32'd0);
   endtask

   task automatic pulseReset();
      @(posedge SCLK); #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_rx_data", 32'(rxMux), 32'd0);
      checkOutput("rst_word_done", 32'(wdMux), 32'd0);
      checkOutput("rst_word_count", 32'(wcMux), 32'd0);
      checkOutput("rst_frame_err", 32'(feMux), 32'd0);
      checkOutput("rst_miso", 32'(misoMux), 32'd0);
      for (int k = 0; k < 3; k++) begin
         mLastRx[k] = '0; mCount[k] = 0; mErr[k] = 1'b0;
      end
      @(negedge SCLK); #1;
      reset = 1'b0;
      csLine = 1'b1;
   endtask

   // Monitor: per negedge, decide from bit counting alone whether a word just completed
   initial begin
      int rxBits;
      int misoBits;
      int pos;
      int w;
      bit expDone;
      logic csS, rstS, misoS;
      logic [15:0] misoAcc;
      logic [15:0] expWord;
      rxBits = 0; misoBits = 0; misoAcc = '0;
      forever begin
         @(negedge SCLK);
         csS = csLine; rstS = reset; misoS = misoMux; w = cfgW[sel];
         #1;
         expDone = 1'b0;
         if (rstS || csS) begin
            rxBits = 0; misoBits = 0; misoAcc = '0;
         end else begin
            rxBits++;
            if (rxBits == w) begin
               expDone = 1'b1;
               rxBits = 0;
            end
            pos = (cfgMsb[sel] != 0) ? (w - 1 - misoBits) : misoBits;
            misoAcc[pos] = misoS;
            misoBits++;
            if (misoBits == w) begin
               if (misoQ.size() == 0) checkOutput("miso_queue_nonempty", 32'd0, 32'd1);
               else begin
                  expWord = misoQ.pop_front();
                  checkOutput("miso_word", 32'(misoAcc), 32'(expWord));
               end
               misoBits = 0; misoAcc = '0;
            end
         end
         checkOutput("word_done", 32'(wdMux), 32'(expDone));
         if (expDone) begin
            if (expRxQ.size() == 0) checkOutput("rx_queue_nonempty", 32'd0, 32'd1);
            else begin
               checkOutput("rx_data", 32'(rxMux), 32'(expRxQ.pop_front()));
               checkOutput("word_count", 32'(wcMux), 32'(expCntQ.pop_front()));
            end
         end
      end
   end

   initial begin
      int nWords;
      int abortBits;
      for (int k = 0; k < 3; k++) begin
         mLastRx[k] = '0; mCount[k] = 0; mErr[k] = 1'b0;
      end
      repeat (2) @(negedge SCLK);
      #1;
      checkOutput("reset_rx_data", 32'(rxMux), 32'd0);
      checkOutput("reset_word_count", 32'(wcMux), 32'd0);
      checkOutput("reset_frame_err", 32'(feMux), 32'd0);
      checkOutput("reset_miso", 32'(misoMux), 32'd0);
      reset = 1'b0;
      @(negedge SCLK); #1;

      $display("[TB] single word, LSB first");
      sel = 0;
      startFrame(); applyStimulus(16'h53, 16'h09); endFrame(0);

      $display("[TB] single word, MSB first");
      sel = 1;
      @(negedge SCLK); #1;
      startFrame(); applyStimulus(16'h53, 16'h09); endFrame(0);

      $display("[TB] three-word burst");
      sel = 0;
      @(negedge SCLK); #1;
      startFrame();
      applyStimulus(16'hA5, 16'h98);
      applyStimulus(16'h3C, 16'h55);
      applyStimulus(16'hFF, 16'h01);
      endFrame(0);

      $display("[TB] abort after five bits");
      startFrame(); applyStimulus(16'h3C, 16'h77); sendPartial(16'h5F, 5); endFrame(5);
      startFrame();
      applyStimulus(16'($urandom), 16'($urandom));
      applyStimulus(16'($urandom), 16'($urandom));
      endFrame(0);

      $display("[TB] reset in the middle of a frame");
      startFrame(); applyStimulus(16'hC3, 16'h81); sendPartial(16'hAA, 4);
      pulseReset();
      @(negedge SCLK); #1;
      startFrame(); applyStimulus(16'h55, 16'hE7); endFrame(0);

      $display("[TB] 16-bit MSB first and counter wrap");
      sel = 2;
      @(negedge SCLK); #1;
      startFrame(); applyStimulus(16'hBEEF, 16'h1234); endFrame(0);
      startFrame();
      for (int i = 0; i < 5; i++) applyStimulus(16'($urandom), 16'($urandom));
      endFrame(0);
      checkOutput("count_wrapped", 32'(wcMux), 32'd1);

      $display("[TB] random frames");
      for (int it = 0; it < 8; it++) begin
         sel = $urandom_range(0, 2);
         @(negedge SCLK); #1;
         nWords = $urandom_range(1, 4);
         abortBits = ($urandom_range(0, 1) == 1) ? $urandom_range(1, cfgW[sel] - 1) : 0;
         startFrame();
         for (int i = 0; i < nWords; i++) applyStimulus(16'($urandom), 16'($urandom));
         if (abortBits > 0) sendPartial(16'($urandom), abortBits);
         endFrame(abortBits);
      end

      repeat (2) @(negedge SCLK);
      #2;
      checkOutput("rx_queue_drained", 32'(expRxQ.size()), 32'd0);
      checkOutput("miso_queue_drained", 32'(misoQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
